carregador_matriz: RTL and testbench

- Upstream feeder for the matrix-negation stage.
- Accepts signed 8-bit elements one per valid/ready handshake, in row-major order, for an N×N matrix (N = 2..5).
- Packs them into the 200-bit 5×5 matrix bus, zero-filling unused positions, then signals completion.
- Its matrix output wires directly to the negation stage's matrix_A input.

---
 rtl/carregador_matriz.sv | 136 +++++++++++++
 tb/tb_carregador_matriz.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/carregador_matriz.sv
// Matrix loader: packs N x N signed elements (row-major, valid/ready) into the 5x5 matrix bus.
// Optional running checksum of accepted elements: define CARREGADOR_CHECKSUM_EN.
module carregador_matriz #(
  parameter int DATA_W   = 8,
  parameter int MAX_DIM  = 5,
  parameter int MATRIX_W = MAX_DIM*MAX_DIM*DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [2:0]          tamanho,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic [MATRIX_W-1:0] matrix_A,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   checksum
);

  localparam int unsigned ELEMS = MAX_DIM*MAX_DIM;
  localparam int          IDX_W = $clog2(ELEMS);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_t;

  state_t           state, nxt;
  logic [2:0]       n_q;
  logic [2:0]       lin, col;
  logic [IDX_W-1:0] count;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] n_ext;
  logic             err_q;
  logic             size_ok, col_last, last;
  logic             do_clear, do_write, latch_n, err_nxt;

  assign size_ok  = (tamanho >= 3'd2) && (tamanho <= 3'd5);
  assign n_ext    = IDX_W'(n_q);
  assign col_last = (col == n_q - 3'd1);
  assign last     = (count == n_ext*n_ext - IDX_W'(1));
  // Storage stride is always MAX_DIM, independent of the loaded N.
  assign idx      = IDX_W'(lin)*IDX_W'(MAX_DIM) + IDX_W'(col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    do_clear = 1'b0;
    do_write = 1'b0;
    latch_n  = 1'b0;
    err_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (size_ok) begin
            latch_n = 1'b1;
            nxt     = S_CLEAR;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (abort) nxt = S_IDLE;
        else begin
          do_clear = 1'b1;
          nxt      = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) nxt = S_IDLE;
        else if (in_valid) begin
          do_write = 1'b1;
          if (last) nxt = S_DONE;
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_CLEAR) || (state == S_LOAD);
  assign done     = (state == S_DONE);
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      lin      <= '0;
      col      <= '0;
      count    <= '0;
      err_q    <= 1'b0;
      matrix_A <= '0;
    end else begin
      err_q <= err_nxt;
      if (latch_n) n_q <= tamanho;
      if (do_clear) begin
        matrix_A <= '0;
        lin      <= '0;
        col      <= '0;
        count    <= '0;
      end else if (do_write) begin
        for (int unsigned e = 0; e < ELEMS; e++) begin
          if (idx == IDX_W'(e)) matrix_A[e*DATA_W +: DATA_W] <= in_data;
        end
        count <= count + IDX_W'(1);
        if (col_last) begin
          col <= '0;
          lin <= lin + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
      end
    end
  end

`ifdef CARREGADOR_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sum_q <= '0;
    else if (do_clear) sum_q <= '0;
    else if (do_write) sum_q <= sum_q + in_data;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_carregador_matriz.sv
// Scoreboard bench for carregador_matriz: expected bus/checksum queued per load, popped at done.
module tb_carregador_matriz;

  localparam int DW = 8;
  localparam int MD = 5;
  localparam int MW = MD*MD*DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [2:0]    tamanho = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, busy, done, err;
  logic [MW-1:0] matrix_A;
  logic [DW-1:0] checksum;

  carregador_matriz #(.DATA_W(DW), .MAX_DIM(MD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .tamanho  (tamanho),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .matrix_A (matrix_A),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0, ready_cnt = 0, busy_cnt = 0, err_cnt = 0;

  logic [MW-1:0] exp_m[$];
  logic [DW-1:0] exp_cs[$];
  logic [MW-1:0] last_m;
  logic [DW-1:0] vals [25];

  always @(negedge clk) begin
    if (rst_n) begin
      if (done)     done_cnt  <= done_cnt + 1;
      if (in_ready) ready_cnt <= ready_cnt + 1;
      if (busy)     busy_cnt  <= busy_cnt + 1;
      if (err)      err_cnt   <= err_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input int n, input bit gaps);
    logic [MW-1:0] m  = '0;
    logic [DW-1:0] cs = '0;
    int  k, cyc;
    bit  ph;
    for (int i = 0; i < n*n; i++) begin
      m[((i/n)*MD + i%n)*DW +: DW] = vals[i];
      cs = cs + vals[i];
    end
`ifndef CARREGADOR_CHECKSUM_EN
    cs = '0;
`endif
    exp_m.push_back(m);
    exp_cs.push_back(cs);
    last_m = m;
    @(posedge clk); #1 start = 1'b1; tamanho = 3'(n);
    @(posedge clk); #1 start = 1'b0;
    k = 0; cyc = 0; ph = 1'b0;
    while (k < n*n && cyc < 300) begin
      in_valid = gaps ? ph : 1'b1;
      in_data  = vals[k];
      #3;
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
      ph = !ph;
      cyc++;
    end
    in_valid = 1'b0;
    check("load_in_budget", MW'(cyc < 300), MW'(1));
    #3;
    check("done_after_last", MW'(done), MW'(1));
    check("matrix_at_done", matrix_A, exp_m.pop_front());
    check("checksum_at_done", MW'(checksum), MW'(exp_cs.pop_front()));
    @(posedge clk); #4;
    check("done_single_pulse", MW'(done), MW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, e0, b0, k, cyc;
    logic [MW-1:0] pm;
    logic [2:0] bad_sz [2];

    #1 rst_n = 1'b0;
    #2;
    check("rst_matrix", matrix_A, '0);
    check("rst_in_ready", MW'(in_ready), MW'(0));
    check("rst_busy", MW'(busy), MW'(0));
    check("rst_done", MW'(done), MW'(0));
    check("rst_err", MW'(err), MW'(0));
    check("rst_checksum", MW'(checksum), MW'(0));
    #9 rst_n = 1'b1;

    // 3x3, no gaps
    for (int i = 0; i < 9; i++) vals[i] = DW'(i + 1);
    r0 = ready_cnt; d0 = done_cnt;
    load(3, 1'b0);
    check("ready_cycles_3x3", MW'(ready_cnt - r0), MW'(9));
    check("done_count_3x3", MW'(done_cnt - d0), MW'(1));
    repeat (3) @(posedge clk);
    #4 check("hold_in_idle", matrix_A, last_m);

    // 5x5 with in_valid toggling
    for (int i = 0; i < 25; i++) vals[i] = DW'(-(i + 1));
    r0 = ready_cnt; d0 = done_cnt;
    load(5, 1'b1);
    check("ready_cycles_5x5", MW'(ready_cnt - r0), MW'(49));
    check("done_count_5x5", MW'(done_cnt - d0), MW'(1));

    // invalid sizes
    e0 = err_cnt; b0 = busy_cnt;
    bad_sz[0] = 3'd1; bad_sz[1] = 3'd6;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1 start = 1'b1; tamanho = bad_sz[s];
      @(posedge clk); #1 start = 1'b0;
      #3 check("err_pulse", MW'(err), MW'(1));
      check("busy_on_err", MW'(busy), MW'(0));
      @(posedge clk); #4 check("err_single", MW'(err), MW'(0));
    end
    check("err_count", MW'(err_cnt - e0), MW'(2));
    check("busy_count_invalid", MW'(busy_cnt - b0), MW'(0));
    check("matrix_kept_invalid", matrix_A, last_m);

    // 4x4 aborted on the 7th element
    for (int i = 0; i < 16; i++) vals[i] = DW'(8'h10 + i);
    pm = '0;
    for (int i = 0; i < 6; i++) pm[((i/4)*MD + i%4)*DW +: DW] = vals[i];
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; tamanho = 3'd4;
    @(posedge clk); #1 start = 1'b0;
    k = 0; cyc = 0;
    while (k < 6 && cyc < 50) begin
      in_valid = 1'b1;
      in_data  = vals[k];
      #3;
      if (in_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    in_data = vals[6]; in_valid = 1'b1; abort = 1'b1;
    #3 check("ready_at_abort", MW'(in_ready), MW'(1));
    @(posedge clk); #1 abort = 1'b0; in_valid = 1'b0;
    #3;
    check("busy_after_abort", MW'(busy), MW'(0));
    check("ready_after_abort", MW'(in_ready), MW'(0));
    check("matrix_partial", matrix_A, pm);
    repeat (3) @(posedge clk);
    #4 check("no_done_after_abort", MW'(done_cnt - d0), MW'(0));

    // new start clears the bus, then async reset mid-load (2x2)
    @(posedge clk); #1 start = 1'b1; tamanho = 3'd2;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #4 check("cleared_by_clear", matrix_A, '0);
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); #1 in_valid = 1'b0;
    #1 check("ready_before_reset", MW'(in_ready), MW'(1));
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_matrix", matrix_A, '0);
    check("async_rst_ready", MW'(in_ready), MW'(0));
    check("async_rst_busy", MW'(busy), MW'(0));
    check("async_rst_done", MW'(done), MW'(0));
    check("async_rst_checksum", MW'(checksum), MW'(0));
    #7 rst_n = 1'b1;

    vals[0] = 8'h7F; vals[1] = 8'h80; vals[2] = 8'h01; vals[3] = 8'h00;
    load(2, 1'b0);

    // checksum wrap: 0x7F+0x7F+0x02+0x01 = 0x101
    vals[0] = 8'h7F; vals[1] = 8'h7F; vals[2] = 8'h02; vals[3] = 8'h01;
    load(2, 1'b0);

    check("scoreboard_empty", MW'(exp_m.size()), MW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
